// File: rtl/seq1010_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : seq1010_rr_scheduler
// Purpose  : One "1010" detector engine shared round-robin among NCH channels.
// Option   : define SEQ1010_MATCH_CNT_EN to build the saturating match counter.
// Revision : 1.0
// ============================================================================
module seq1010_rr_scheduler #(
  parameter int NCH  = 4,
  parameter int CHW  = 2,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NCH-1:0]  req,
  input  logic [NCH-1:0]  d,
  input  logic [NCH-1:0]  clr,
  output logic [NCH-1:0]  gnt,
  output logic            match_valid,
  output logic [CHW-1:0]  match_ch,
  output logic [2:0]      state_mon,
  output logic [CNTW-1:0] match_count
);

  typedef enum logic [2:0] {
    S0 = 3'b000,
    S1 = 3'b001,
    S2 = 3'b010,
    S3 = 3'b011,
    S4 = 3'b100
  } state_t;

  state_t         r_state [NCH];
  state_t         r_state_mon;
  logic [CHW-1:0] r_ptr;
  logic           r_match_valid;
  logic [CHW-1:0] r_match_ch;

  logic [NCH-1:0] w_elig;
  logic [NCH-1:0] w_gnt;
  logic [CHW-1:0] w_gnt_idx;
  logic           w_any;
  state_t         w_new_state;
  logic           w_hit;

  // Pointer stays below NCH and offsets are below NCH, so one subtract wraps.
  function automatic logic [CHW-1:0] wrap_idx(input logic [CHW-1:0] p, input int off);
    int s;
    s = int'(p) + off;
    if (s >= NCH) s = s - NCH;
    return s[CHW-1:0];
  endfunction

  function automatic state_t next_state(input state_t s, input logic b);
    state_t n;
    n = S0;
    case (s)
      S0:      n = b ? S1 : S0;
      S1:      n = b ? S1 : S2;
      S2:      n = b ? S3 : S0;
      S3:      n = b ? S1 : S4;
      S4:      n = b ? S3 : S0;
      default: n = S0;
    endcase
    return n;
  endfunction

  assign w_elig = req & ~clr;

  always_comb begin
    w_any     = 1'b0;
    w_gnt_idx = '0;
    w_gnt     = '0;
    for (int off = 0; off < NCH; off++) begin
      if (!w_any && w_elig[wrap_idx(r_ptr, off)]) begin
        w_any     = 1'b1;
        w_gnt_idx = wrap_idx(r_ptr, off);
      end
    end
    w_gnt[w_gnt_idx] = w_any;
  end

  always_comb begin
    w_new_state = next_state(r_state[w_gnt_idx], d[w_gnt_idx]);
    w_hit       = w_any && (w_new_state == S4);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NCH; i++) r_state[i] <= S0;
      r_ptr         <= '0;
      r_match_valid <= 1'b0;
      r_match_ch    <= '0;
      r_state_mon   <= S0;
    end else begin
      // A cleared channel is never eligible, so clear and service cannot collide.
      for (int i = 0; i < NCH; i++) begin
        if (clr[i]) begin
          r_state[i] <= S0;
        end else if (w_any && (w_gnt_idx == i[CHW-1:0])) begin
          r_state[i] <= w_new_state;
        end
      end
      r_match_valid <= w_hit;
      if (w_any) begin
        r_ptr       <= wrap_idx(w_gnt_idx, 1);
        r_match_ch  <= w_gnt_idx;
        r_state_mon <= w_new_state;
      end
    end
  end

`ifdef SEQ1010_MATCH_CNT_EN
  logic [CNTW-1:0] r_match_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_match_count <= '0;
    end else if (w_hit && (r_match_count != {CNTW{1'b1}})) begin
      r_match_count <= r_match_count + 1'b1;
    end
  end

  assign match_count = r_match_count;
`else
  assign match_count = '0;
`endif

  assign gnt         = w_gnt;
  assign match_valid = r_match_valid;
  assign match_ch    = r_match_ch;
  assign state_mon   = r_state_mon;

endmodule
`default_nettype wire
